// File: rtl/maj_bist_pkg.sv
// maj_bist_pkg: shared state encoding and majority reference helpers for maj_sweep_bist
package maj_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
  localparam int MAX_W = 32;
  function automatic int popcount(input logic [MAX_W-1:0] v, input int w);
    int c;
    c = 0;
    for (int i = 0; i < MAX_W; i++) if (i < w) c += int'(v[i]);
    return c;
  endfunction
  function automatic int maj_threshold(input int n);
    return (n + 1) / 2;
  endfunction
endpackage

// File: rtl/maj_ref.sv
// maj_ref: combinational N-input majority reference (popcount >= (N+1)/2)
module maj_ref
  import maj_bist_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] x_i,
  output logic         y_o
);
  assign y_o = popcount(MAX_W'(x_i), N) >= maj_threshold(N);
endmodule

// File: rtl/maj_sweep_bist.sv
// maj_sweep_bist: exhaustive sweep BIST for an N-input majority gate; MAJ_SWEEP_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module maj_sweep_bist
  import maj_bist_pkg::*;
#(
  parameter int N             = 9,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         y0,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   mismatch_count,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_e         state_q;
  logic [N-1:0]   x_q, ffvec_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q, pass_q, ffv_q;
  logic [N:0]     mc_q, mc_d;
  logic           ref_w, mism, stop;
  maj_ref #(.N(N)) u_ref (.x_i(x_q), .y_o(ref_w));
  assign mism = y0 != ref_w;
  assign mc_d = mc_q + (N+1)'(mism);
`ifdef MAJ_SWEEP_BIST_STOP_ON_FAIL_EN
  assign stop = mism;
`else
  assign stop = 1'b0;
`endif
  assign x                = x_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mc_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  // Sweep FSM: hold each vector SETTLE_CYCLES cycles, then compare gate output against the reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mc_q    <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= SETTLE;
          x_q     <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          mc_q    <= '0;
          ffv_q   <= 1'b0;
          ffvec_q <= '0;
        end
        SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          mc_q <= mc_d;
          if (mism && !ffv_q) begin
            ffv_q   <= 1'b1;
            ffvec_q <= x_q;
          end
          if ((&x_q) || stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= mc_d == '0;
          end else begin
            state_q <= SETTLE;
            x_q     <= x_q + 1'b1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maj_sweep_bist.sv
// tb_maj_sweep_bist: directed sweeps against good, stuck-at and single-fault majority gate models
module tb_maj_sweep_bist;
`ifdef MAJ_SWEEP_BIST_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, y0;
  logic [8:0] x, first_fail_vec;
  logic [9:0] mismatch_count;
  logic       busy, done, pass, first_fail_valid;
  int         mode = 0, total = 0, bad = 0, cyc;

  maj_sweep_bist #(.N(9), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y0(y0), .x(x), .busy(busy), .done(done),
    .pass(pass), .mismatch_count(mismatch_count), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  // 0 good gate, 1 stuck-at-0, 2 stuck-at-1, 3 wrong only at 9'h1F0
  assign y0 = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 :
              mode == 3 && x == 9'h1F0 ? 1'b0 : ($countones(x) >= 5);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_cnt"}, 32'(mismatch_count), 0);
    check({tag, "_ffv"}, 32'(first_fail_valid), 0);
    check({tag, "_ffvec"}, 32'(first_fail_vec), 0);
  endtask

  // Pulse start, then count cycles from busy rising to done rising; optional mid-sweep start pulse
  task automatic sweep(input int m, input string tag, input int pulse_at);
    mode = m;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 1);
    check({tag, "_x_start"}, 32'(x), 0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == pulse_at) start = 1'b1;
      if (cyc == pulse_at + 1) start = 1'b0;
    end
    check({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    #12;
    outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    sweep(0, "good", 100);
    check("good_cycles", cyc, 1536);
    check("good_pass", 32'(pass), 1);
    check("good_cnt", 32'(mismatch_count), 0);
    check("good_ffv", 32'(first_fail_valid), 0);
    check("good_x", 32'(x), 32'h1FF);

    sweep(1, "sa0", -5);
    check("sa0_cycles", cyc, SOF ? 96 : 1536);
    check("sa0_pass", 32'(pass), 0);
    check("sa0_cnt", 32'(mismatch_count), SOF ? 1 : 256);
    check("sa0_ffv", 32'(first_fail_valid), 1);
    check("sa0_ffvec", 32'(first_fail_vec), 32'h01F);
    check("sa0_x", 32'(x), SOF ? 32'h01F : 32'h1FF);

    sweep(2, "sa1", -5);
    check("sa1_cycles", cyc, SOF ? 3 : 1536);
    check("sa1_pass", 32'(pass), 0);
    check("sa1_cnt", 32'(mismatch_count), SOF ? 1 : 256);
    check("sa1_ffvec", 32'(first_fail_vec), 32'h000);

    sweep(3, "one", -5);
    check("one_cycles", cyc, SOF ? 1491 : 1536);
    check("one_pass", 32'(pass), 0);
    check("one_cnt", 32'(mismatch_count), 1);
    check("one_ffv", 32'(first_fail_valid), 1);
    check("one_ffvec", 32'(first_fail_vec), 32'h1F0);

    // Abort a good sweep with reset at cycle 500, then rerun from scratch
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (499) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    outputs_zero("abort");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_busy", 32'(busy), 0);
    sweep(0, "rerun", -5);
    check("rerun_cycles", cyc, 1536);
    check("rerun_pass", 32'(pass), 1);
    check("rerun_cnt", 32'(mismatch_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/maj_sweep_bist.md
# maj_sweep_bist

Exhaustive built-in self-test sequencer for an N-input majority gate such as the 9-input `top` majority network. It sits directly upstream of the gate under test, driving its input vector through all 2^N combinations. It samples the gate's output after a programmable settle time and compares it against an internal popcount-threshold reference. Results are reported as pass/fail, a mismatch count, and the first failing vector.

## Interface
- `N`, 9: majority width; must be odd and ≥ 3.
- `SETTLE_CYCLES`, 2: cycles the vector is held before sampling; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse to begin a sweep; sampled only in IDLE or DONE.
- `y0` in 1: output of the majority gate under test.
- `x` out N: registered stimulus vector driving the gate inputs.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: high from sweep completion until the next start or reset.
- `pass` out 1: valid while `done`; 1 when `mismatch_count` == 0.
- `mismatch_count` out N+1: number of failing vectors; saturation is not needed because the maximum is 2^N.
- `first_fail_valid` out 1: set on the first mismatch of a sweep.
- `first_fail_vec` out N: `x` value at the first mismatch.

## Operation
- Reference: ref = (popcount(x) ≥ (N+1)/2). It is computed from registered `x`, never from `y0`.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, `start`=1:
  - `x`←0, settle counter←0, `mismatch_count`←0.
  - `first_fail_valid`←0, `first_fail_vec`←0, `done`←0, `pass`←0, `busy`←1.
  - Next state SETTLE.
- SETTLE: the counter increments each cycle. When counter == SETTLE_CYCLES−1, go to SAMPLE.
- SAMPLE:
  - If `y0` ≠ ref: `mismatch_count`++. If `first_fail_valid`=0, also `first_fail_vec`←`x` and `first_fail_valid`←1.
  - If `x` is all-ones: go to DONE.
  - Otherwise `x`←`x`+1, counter←0, go to SETTLE.
- DONE entry: `busy`←0, `done`←1, `pass`←(final count == 0). The final count includes the mismatch from the last SAMPLE. `x` holds all-ones.
- `start` while `busy` is ignored.
- `x` increments without wrap: the sweep ends at all-ones, so there is no terminal +1.

## Timing
- Reset values: all outputs 0. The FSM resets to IDLE. Assertion of `rst_n` mid-sweep aborts the sweep immediately, with no partial result retained.
- Cycles per vector: SETTLE_CYCLES+1.
- `busy` rises the cycle after `start` is sampled.
- `done` rises 2^N·(SETTLE_CYCLES+1) cycles after that. With N=9 and S=2 this is 1536 cycles.
- `y0` is sampled in the SAMPLE cycle. The gate must settle within SETTLE_CYCLES cycles of the `x` update.
- A mismatch in the same SAMPLE cycle as the last vector is counted before `pass` is evaluated.
- `start` asserted in the same cycle as DONE entry is not seen; it is sampled only once in DONE.

## Configuration
- Macro: `MAJ_SWEEP_BIST_STOP_ON_FAIL_EN`.
- Defined: the first mismatch transitions SAMPLE→DONE immediately. In that case `mismatch_count`=1, `pass`=0, and `x` holds the failing vector.
- Undefined: the full 2^N sweep always completes.

## Structure
- Package `maj_bist_pkg` holds:
  - the state enum;
  - the `popcount` function, parameterised by width;
  - the `maj_threshold(N)` constant function.
- Sub-module `maj_ref`: a combinational reference (N-bit in, 1-bit out) instantiated inside the sequencer.

## Test plan
- Correct 9-input majority model, S=2: `done` asserts 1536 cycles after `busy` rises; `pass`=1, `mismatch_count`=0, `first_fail_valid`=0.
- Gate stuck-at-0: `mismatch_count`=256, `first_fail_vec`=9'h01F, `pass`=0.
- Gate stuck-at-1: `mismatch_count`=256, `first_fail_vec`=9'h000.
- Gate wrong only at 9'h1F0: `mismatch_count`=1, `first_fail_vec`=9'h1F0.
- Reset pulsed at cycle 500, then `start`: all outputs are 0 during reset, and the sweep restarts at `x`=0 and completes normally. `start` pulsed mid-sweep has no effect.
- With `MAJ_SWEEP_BIST_STOP_ON_FAIL_EN` and gate stuck-at-0: `done` asserts after 32·3 cycles, `x`=9'h01F, `mismatch_count`=1.
